// File: rtl/mem_arbiter_ctrl.sv
// Round-robin arbiter that lets four processors share one memory port.
// Each transaction runs IDLE -> ISSUE -> WAIT -> DONE and can end early on a response timeout.
module mem_arbiter_ctrl #(
    parameter int NUM_PROCESSORS = 4,
    parameter int ADDR_W         = 14,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT        = 15
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_PROCESSORS-1:0]        i_req,
    input  logic [NUM_PROCESSORS-1:0]        i_we,
    input  logic [NUM_PROCESSORS*ADDR_W-1:0] i_addr_in,
    input  logic [NUM_PROCESSORS*DATA_W-1:0] i_wdata_in,
    output logic [NUM_PROCESSORS-1:0]        o_gnt,
    output logic [NUM_PROCESSORS-1:0]        o_done,
    output logic [NUM_PROCESSORS-1:0]        o_err,
    output logic [DATA_W-1:0]                o_rdata_out,
    output logic                             o_mem_read_req,
    output logic                             o_mem_write_req,
    output logic [ADDR_W-1:0]                o_mem_addr,
    output logic [DATA_W-1:0]                o_mem_write_data,
    output logic [NUM_PROCESSORS-1:0]        o_mem_proc_req,
    input  logic [DATA_W-1:0]                i_mem_read_data,
    input  logic [NUM_PROCESSORS-1:0]        i_mem_resp
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic [1:0]                r_state;
    logic [1:0]                r_ptr;
    logic [1:0]                r_win;
    logic                      r_we;
    logic                      r_abort;
    logic [7:0]                r_cnt;
    logic [NUM_PROCESSORS-1:0] r_gnt;
    logic [ADDR_W-1:0]         r_addr;
    logic [DATA_W-1:0]         r_wdata;
    logic [DATA_W-1:0]         r_rdata;

    logic [1:0]                w_pick;
    logic                      w_any;
    logic                      w_win_resp;
    logic [7:0]                w_cnt_inc;

    // Scan offsets high to low so the requester closest above r_ptr wins.
    always_comb begin
        w_pick = r_ptr;
        for (int k = NUM_PROCESSORS - 1; k >= 0; k--) begin
            if (i_req[2'(r_ptr + 2'(k))]) begin
                w_pick = 2'(r_ptr + 2'(k));
            end
        end
    end

    assign w_any      = |i_req;
    assign w_win_resp = i_mem_resp[r_win];
    assign w_cnt_inc  = r_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_we    <= 1'b0;
            r_abort <= 1'b0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_win   <= w_pick;
                        r_we    <= i_we[w_pick];
                        r_addr  <= i_addr_in[w_pick*ADDR_W +: ADDR_W];
                        r_wdata <= i_wdata_in[w_pick*DATA_W +: DATA_W];
                        r_gnt   <= NUM_PROCESSORS'(1) << w_pick;
                        r_abort <= 1'b0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A response wins even in the cycle the counter would expire.
                    if (w_win_resp) begin
                        if (!r_we) begin
                            r_rdata <= i_mem_read_data;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == TIMEOUT_C) begin
                            r_abort <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_ptr   <= 2'(r_win + 2'd1);
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_gnt            = r_gnt;
    assign o_done           = (r_state == S_DONE) ? r_gnt : '0;
    assign o_err            = (r_state == S_DONE && r_abort) ? r_gnt : '0;
    assign o_rdata_out      = r_rdata;
    assign o_mem_read_req   = (r_state == S_ISSUE) && !r_we;
    assign o_mem_write_req  = (r_state == S_ISSUE) && r_we;
    assign o_mem_proc_req   = (r_state == S_ISSUE || r_state == S_WAIT) ? r_gnt : '0;
    assign o_mem_addr       = r_addr;
    assign o_mem_write_data = r_wdata;

endmodule
